// File: rtl/fp_sqrt_iter.sv
// fp_sqrt_iter: multi-cycle floating-point square root (fp16 by default).
// A restoring digit-by-digit recurrence produces one root bit per clock.
// Exact mode computes all MAN_W+1 root bits. Approximate mode stops after
// APPROX_ITERS bits and zero-fills the remaining low bits. Operands arrive and
// results leave through valid/ready handshakes.
module fp_sqrt_iter #(
    parameter int EXP_W        = 5,
    parameter int MAN_W        = 10,
    parameter int BIAS         = 15,
    parameter int APPROX_ITERS = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_data,
    input  logic                   in_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_data,
    output logic                   out_invalid,
    output logic                   busy
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int RT_W  = MAN_W + 1;          // root width incl. hidden one
    localparam int RAD_W = 2 * MAN_W + 2;      // radicand width
    localparam int REM_W = MAN_W + 3;          // partial remainder width
    localparam int TR_W  = REM_W + 2;          // trial difference width
    localparam int CNT_W = $clog2(MAN_W + 2);
    localparam int EW_S  = EXP_W + 2;          // signed exponent arithmetic width

    localparam logic signed [EW_S-1:0] BIAS_S       = EW_S'(BIAS);
    localparam logic [CNT_W-1:0]       CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0]       ITER_EXACT   = CNT_W'(MAN_W + 1);
    localparam logic [CNT_W-1:0]       ITER_APPROX  = CNT_W'(APPROX_ITERS);
    localparam logic [CNT_W-1:0]       SHIFT_EXACT  = CNT_W'(0);
    localparam logic [CNT_W-1:0]       SHIFT_APPROX = CNT_W'(MAN_W + 1 - APPROX_ITERS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;

    logic [RAD_W-1:0]   rad_r;
    logic [REM_W-1:0]   rem_r;
    logic [RT_W-1:0]    root_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   shift_r;
    logic [EXP_W-1:0]   exp_r;

    logic [W-1:0]       out_data_r;
    logic               out_invalid_r;
    logic               out_valid_r;
    logic               in_ready_r;
    logic               busy_r;

    logic               in_ready_nxt_s;
    logic               out_valid_nxt_s;
    logic               busy_nxt_s;

    // Operand decode
    logic               op_sign_s;
    logic [EXP_W-1:0]   op_exp_s;
    logic [MAN_W-1:0]   op_man_s;
    logic               exp_zero_s;
    logic               exp_ones_s;
    logic               special_s;
    logic [W-1:0]       special_data_s;
    logic               special_inv_s;
    logic signed [EW_S-1:0] e_s;
    logic signed [EW_S-1:0] k_s;
    logic [EXP_W-1:0]   out_exp_s;
    logic [RAD_W-1:0]   rad_init_s;

    // Recurrence step
    logic [1:0]         pair_s;
    logic [TR_W-1:0]    trial_s;
    logic               bit_s;
    logic [REM_W-1:0]   rem_nxt_s;
    logic [RT_W-1:0]    root_nxt_s;
    logic [MAN_W-1:0]   man_res_s;

    assign op_sign_s = in_data[W-1];
    assign op_exp_s  = in_data[MAN_W +: EXP_W];
    assign op_man_s  = in_data[MAN_W-1:0];

    // Classify the operand, pick the special-case result and prepare the radicand.
    always_comb begin
        exp_zero_s = (op_exp_s == {EXP_W{1'b0}});
        exp_ones_s = &op_exp_s;
        special_s  = exp_zero_s | op_sign_s | exp_ones_s;

        special_data_s = in_data;
        special_inv_s  = 1'b0;
        if (exp_zero_s) begin
            // Zero and denormals both flush to a signed zero.
            special_data_s = {op_sign_s, {(W-1){1'b0}}};
            special_inv_s  = 1'b0;
        end else if (op_sign_s) begin
            special_data_s = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            special_inv_s  = 1'b1;
        end else begin
            // Infinity/NaN pass through; normals never use this value.
            special_data_s = in_data;
            special_inv_s  = 1'b0;
        end

        e_s       = $signed({2'b00, op_exp_s}) - BIAS_S;
        k_s       = e_s >>> 1;
        out_exp_s = EXP_W'(k_s + BIAS_S);

        // An odd exponent moves one factor of two into the radicand.
        if (e_s[0]) begin
            rad_init_s = {1'b1, op_man_s, {(MAN_W+1){1'b0}}};
        end else begin
            rad_init_s = {1'b0, 1'b1, op_man_s, {MAN_W{1'b0}}};
        end
    end

    // One restoring iteration: try subtracting {root, 01} from {rem, next pair}.
    always_comb begin
        pair_s  = rad_r[RAD_W-1 -: 2];
        trial_s = {rem_r, pair_s} - {2'b00, root_r, 2'b01};
        // A valid non-negative remainder always fits in REM_W bits, so any
        // higher bit set means the subtraction went negative.
        bit_s   = ~(|trial_s[TR_W-1:REM_W]);
        if (bit_s) begin
            rem_nxt_s = trial_s[REM_W-1:0];
        end else begin
            rem_nxt_s = {rem_r[REM_W-3:0], pair_s};
        end
        root_nxt_s = {root_r[RT_W-2:0], bit_s};
        // Left-align a truncated root; the MSB is the implicit one.
        man_res_s  = MAN_W'(root_nxt_s << shift_r);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt_s = special_s ? ST_DONE : ST_CALC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CALC;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Handshake/status flags derived from the upcoming state, registered below.
    always_comb begin
        in_ready_nxt_s  = 1'b0;
        out_valid_nxt_s = 1'b0;
        busy_nxt_s      = 1'b1;
        case (state_nxt_s)
            ST_IDLE: begin
                in_ready_nxt_s  = 1'b1;
                out_valid_nxt_s = 1'b0;
                busy_nxt_s      = 1'b0;
            end
            ST_CALC: begin
                in_ready_nxt_s  = 1'b0;
                out_valid_nxt_s = 1'b0;
                busy_nxt_s      = 1'b1;
            end
            ST_DONE: begin
                in_ready_nxt_s  = 1'b0;
                out_valid_nxt_s = 1'b1;
                busy_nxt_s      = 1'b1;
            end
            default: begin
                in_ready_nxt_s  = 1'b1;
                out_valid_nxt_s = 1'b0;
                busy_nxt_s      = 1'b0;
            end
        endcase
    end

    // Registered handshake/status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    // Datapath: latch operand on accept, iterate in CALC, capture the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rad_r         <= {RAD_W{1'b0}};
            rem_r         <= {REM_W{1'b0}};
            root_r        <= {RT_W{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            shift_r       <= {CNT_W{1'b0}};
            exp_r         <= {EXP_W{1'b0}};
            out_data_r    <= {W{1'b0}};
            out_invalid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (special_s) begin
                            out_data_r    <= special_data_s;
                            out_invalid_r <= special_inv_s;
                        end else begin
                            rad_r   <= rad_init_s;
                            rem_r   <= {REM_W{1'b0}};
                            root_r  <= {RT_W{1'b0}};
                            cnt_r   <= in_mode ? ITER_APPROX : ITER_EXACT;
                            shift_r <= in_mode ? SHIFT_APPROX : SHIFT_EXACT;
                            exp_r   <= out_exp_s;
                        end
                    end
                end
                ST_CALC: begin
                    rad_r  <= {rad_r[RAD_W-3:0], 2'b00};
                    rem_r  <= rem_nxt_s;
                    root_r <= root_nxt_s;
                    cnt_r  <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        out_data_r    <= {1'b0, exp_r, man_res_s};
                        out_invalid_r <= 1'b0;
                    end
                end
                default: begin
                    // DONE holds the result stable until it is taken.
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign busy        = busy_r;
    assign out_data    = out_data_r;
    assign out_invalid = out_invalid_r;

endmodule

// File: tb/tb_fp_sqrt_iter.sv
// tb_fp_sqrt_iter: scoreboard-driven bench for the fp16 iterative square root.
module tb_fp_sqrt_iter;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_invalid;
    logic         busy;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [15:0] data;
        logic        inv;
        int          lat;
    } exp_t;

    exp_t sb[$];

    // 100 MHz clock.
    always #5 clk = ~clk;

    fp_sqrt_iter dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_invalid(out_invalid),
        .busy       (busy)
    );

    // Independent reference: integer floor-sqrt by bit search.
    function automatic void model(input logic [15:0] d, input logic m,
                                  output logic [15:0] od, output logic oi, output int ol);
        int ex, e, k, mant, rad, r, t;
        ex   = int'(d[14:10]);
        mant = int'({1'b1, d[9:0]});
        oi   = 1'b0;
        ol   = 0;
        if (ex == 0) begin
            od = {d[15], 15'h0000};
        end else if (d[15]) begin
            od = 16'h7E00;
            oi = 1'b1;
        end else if (ex == 31) begin
            od = d;
        end else begin
            e   = ex - 15;
            k   = (e - ((e % 2 != 0) ? 1 : 0)) / 2;
            rad = mant << ((e % 2 != 0) ? 11 : 10);
            r   = 0;
            for (int b = 11; b >= 0; b--) begin
                t = r + (1 << b);
                if (t * t <= rad) r = t;
            end
            if (m) r = r & ~31;
            od = {1'b0, 5'(k + 15), 10'(r)};
            ol = m ? 6 : 11;
        end
    endfunction

    // Present one operand while the DUT is idle; push its expected result.
    task automatic start_op(input logic [15:0] d, input logic m,
                            input logic [15:0] ed, input logic ei, input int el);
        exp_t e;
        e.data = ed;
        e.inv  = ei;
        e.lat  = el;
        sb.push_back(e);
        in_data  = d;
        in_mode  = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_mode  = 1'($urandom);
    endtask

    // Count edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_out(output int lat, output bit to);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        to = (out_valid !== 1'b1);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        in_mode   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (out_data !== 16'h0000) $display("FAIL reset_out_data: got %h want 0000", out_data); else passed++;
        total++; if (out_invalid !== 1'b0) $display("FAIL reset_out_invalid: got %b want 0", out_invalid); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_exact();
        logic [15:0] ops [3] = '{16'h4400, 16'h4000, 16'h3400};
        logic [15:0] res [3] = '{16'h4000, 16'h3DA8, 16'h3800};
        exp_t e;
        int lat;
        bit to;
        for (int i = 0; i < 3; i++) begin
            start_op(ops[i], 1'b0, res[i], 1'b0, 11);
            wait_out(lat, to);
            e = sb.pop_front();
            total++;
            if (to || out_data !== e.data || out_invalid !== e.inv)
                $display("FAIL exact_%h: got %h inv %b want %h inv %b", ops[i], out_data, out_invalid, e.data, e.inv);
            else passed++;
            total++; if (lat != e.lat) $display("FAIL exact_lat_%h: got %0d want %0d", ops[i], lat, e.lat); else passed++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_approx();
        logic [15:0] ops [2] = '{16'h4000, 16'h4400};
        logic [15:0] res [2] = '{16'h3DA0, 16'h4000};
        exp_t e;
        int lat;
        bit to;
        for (int i = 0; i < 2; i++) begin
            start_op(ops[i], 1'b1, res[i], 1'b0, 6);
            wait_out(lat, to);
            e = sb.pop_front();
            total++;
            if (to || out_data !== e.data || out_invalid !== e.inv)
                $display("FAIL approx_%h: got %h inv %b want %h inv %b", ops[i], out_data, out_invalid, e.data, e.inv);
            else passed++;
            total++; if (lat != e.lat) $display("FAIL approx_lat_%h: got %0d want %0d", ops[i], lat, e.lat); else passed++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_special();
        logic [15:0] ops [7] = '{16'hC400, 16'h8000, 16'h0001, 16'h7C00, 16'hFC00, 16'h7E01, 16'h8001};
        logic [15:0] res [7] = '{16'h7E00, 16'h8000, 16'h0000, 16'h7C00, 16'h7E00, 16'h7E01, 16'h8000};
        logic        inv [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_t e;
        int lat;
        bit to;
        for (int i = 0; i < 7; i++) begin
            start_op(ops[i], 1'($urandom), res[i], inv[i], 0);
            wait_out(lat, to);
            e = sb.pop_front();
            total++;
            if (to || out_data !== e.data || out_invalid !== e.inv)
                $display("FAIL special_%h: got %h inv %b want %h inv %b", ops[i], out_data, out_invalid, e.data, e.inv);
            else passed++;
            total++; if (lat != e.lat) $display("FAIL special_lat_%h: got %0d want %0d", ops[i], lat, e.lat); else passed++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int lat;
        bit to;
        out_ready = 1'b0;
        start_op(16'h3C00, 1'b0, 16'h3C00, 1'b0, 11);
        wait_out(lat, to);
        e = sb.pop_front();
        total++;
        if (to || out_data !== e.data || lat != e.lat)
            $display("FAIL bp_first: got %h lat %0d want %h lat %0d", out_data, lat, e.data, e.lat);
        else passed++;
        // Hold a second operand on the input while the result is stalled.
        in_valid = 1'b1;
        in_data  = 16'h4400;
        in_mode  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 1'b1 || out_data !== 16'h3C00 || in_ready !== 1'b0 || busy !== 1'b1)
                $display("FAIL bp_hold_%0d: valid %b data %h ready %b busy %b want 1 3c00 0 1",
                         c, out_valid, out_data, in_ready, busy);
            else passed++;
        end
        e.data = 16'h4000;
        e.inv  = 1'b0;
        e.lat  = 11;
        sb.push_back(e);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_release: valid %b ready %b want 0 1", out_valid, in_ready);
        else passed++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL bp_accept: busy %b ready %b want 1 0", busy, in_ready);
        else passed++;
        wait_out(lat, to);
        e = sb.pop_front();
        total++;
        if (to || out_data !== e.data || lat != e.lat)
            $display("FAIL bp_second: got %h lat %0d want %h lat %0d", out_data, lat, e.data, e.lat);
        else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int lat;
        bit to;
        bit seen;
        start_op(16'h4000, 1'b0, 16'h3DA8, 1'b0, 11);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL rst_mid_state: ready %b busy %b valid %b want 1 0 0", in_ready, busy, out_valid);
        else passed++;
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        total++; if (seen) $display("FAIL rst_mid_no_output: got out_valid 1 want 0"); else passed++;
        start_op(16'h4400, 1'b0, 16'h4000, 1'b0, 11);
        wait_out(lat, to);
        e = sb.pop_front();
        total++;
        if (to || out_data !== e.data || lat != e.lat)
            $display("FAIL rst_mid_next: got %h lat %0d want %h lat %0d", out_data, lat, e.data, e.lat);
        else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [15:0] d;
        logic        m;
        logic [15:0] ed;
        logic        ei;
        int          el;
        exp_t        e;
        int          lat;
        bit          to;
        for (int i = 0; i < 40; i++) begin
            d = {1'b0, 5'($urandom_range(1, 30)), 10'($urandom_range(0, 1023))};
            m = 1'($urandom_range(0, 1));
            model(d, m, ed, ei, el);
            start_op(d, m, ed, ei, el);
            wait_out(lat, to);
            e = sb.pop_front();
            total++;
            if (to || out_data !== e.data || out_invalid !== e.inv || lat != e.lat)
                $display("FAIL random_%0d op %h mode %b: got %h inv %b lat %0d want %h inv %b lat %0d",
                         i, d, m, out_data, out_invalid, lat, e.data, e.inv, e.lat);
            else passed++;
            @(posedge clk);
            #1;
        end
    endtask

    // Bound the run time.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Test sequence.
    initial begin
        test_reset();
        test_exact();
        test_approx();
        test_special();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
